// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU bus slave terminator.
package cpu_bus_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STROBE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_TERM   = 3'd3;
  localparam logic [2:0] ST_BURST  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_STROBE = ST_STROBE,
    S_WAIT   = ST_WAIT,
    S_TERM   = ST_TERM,
    S_BURST  = ST_BURST,
    S_HOLD   = ST_HOLD,
    S_ERR    = ST_ERR
  } term_state_e;

  // DSACK_ encodings: both low = 32-bit port, both high = no termination.
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  localparam int         BURST_BEATS = 4;
  localparam logic [1:0] LAST_BEAT   = 2'(BURST_BEATS - 1);

endpackage

// File: rtl/as_sync.sv
// Two-flop synchroniser for active-low asynchronous CPU strobes; resets to the negated level.
module as_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw strobe through two flops; reset to 1 so nothing looks asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/cpu_term_gen.sv
// Slave-side 68030 bus cycle terminator: strobes the backend and answers with
// DSACK_/STERM_ (with CBACK_ bursts) or BERR_ when the backend never responds.
module cpu_term_gen
  import cpu_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 63
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       AS_,
  input  logic       RW,
  input  logic       SEL,
  input  logic [1:0] A32,
  input  logic       SYNC_EN,
  input  logic       CBREQ_,
  input  logic       BE_ACK,
  output logic       RD_STB,
  output logic       WR_STB,
  output logic [1:0] BEAT,
  output logic       DOE,
  output logic [1:0] DSACK_,
  output logic       STERM_,
  output logic       CBACK_,
  output logic       BERR_
);

  logic as_s, cbreq_s;

  as_sync u_as_sync (
    .clk_i(SCLK),
    .rst_i(RST),
    .d_i  (AS_),
    .q_o  (as_s)
  );

  as_sync u_cbreq_sync (
    .clk_i(SCLK),
    .rst_i(RST),
    .d_i  (CBREQ_),
    .q_o  (cbreq_s)
  );

  term_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;     // beats completed within this burst
  logic [1:0]  beat_q, beat_d;     // long-word index presented on BEAT
  logic        sync_q, sync_d;
  logic        burst_q, burst_d;   // burst still wanted by the CPU
  logic        pend_q, pend_d;     // BE_ACK seen before wait states elapsed
  logic        rd_stb_q, rd_stb_d;
  logic        wr_stb_q, wr_stb_d;
  logic        doe_q, doe_d;
  logic [1:0]  dsack_q, dsack_d;
  logic        sterm_q, sterm_d;
  logic        cback_q, cback_d;
  logic        berr_q, berr_d;

  logic elapsed_ok, timeout_hit, burst_stop;

  // The strobe cycle counts toward the wait, so cnt+1 is the cycles since strobe.
  assign elapsed_ok  = ({1'b0, cnt_q} + 9'd1) >= 9'(WAIT_STATES);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT));
  assign burst_stop  = cbreq_s | ~burst_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    beat_d   = beat_q;
    sync_d   = sync_q;
    burst_d  = burst_q;
    pend_d   = pend_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    sterm_d  = 1'b1;
    doe_d    = doe_q;
    dsack_d  = dsack_q;
    cback_d  = cback_q;
    berr_d   = berr_q;

    unique case (state_q)
      S_IDLE: begin
        dsack_d = DSACK_NONE;
        cback_d = 1'b1;
        berr_d  = 1'b1;
        doe_d   = 1'b0;
        if (!as_s && SEL) begin
          state_d  = S_STROBE;
          sync_d   = SYNC_EN;
          beat_d   = A32;
          bidx_d   = '0;
          pend_d   = 1'b0;
          burst_d  = SYNC_EN & RW & ~cbreq_s;
          rd_stb_d = RW;
          wr_stb_d = ~RW;
          doe_d    = RW;
        end
      end

      S_STROBE: begin
        if (as_s) begin
          state_d = S_IDLE;
          doe_d   = 1'b0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
          pend_d  = BE_ACK;
        end
      end

      S_WAIT: begin
        if (as_s) begin
          state_d = S_IDLE;
          doe_d   = 1'b0;
        end else if ((BE_ACK || pend_q) && elapsed_ok) begin
          // Acknowledge beats the timeout when both land on the same cycle.
          state_d = S_TERM;
          if (sync_q) begin
            sterm_d = 1'b0;
            cback_d = ~(burst_q & ~cbreq_s);
            burst_d = burst_q & ~cbreq_s;
          end else begin
            dsack_d = DSACK_32;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
          berr_d  = 1'b0;
          doe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (BE_ACK) pend_d = 1'b1;
        end
      end

      S_TERM: begin
        if (burst_q && (bidx_q != LAST_BEAT) && !cbreq_s) begin
          state_d  = S_BURST;
          beat_d   = beat_q + 2'd1;
          bidx_d   = bidx_q + 2'd1;
          rd_stb_d = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d = S_HOLD;
          cback_d = 1'b1;
        end
      end

      S_BURST: begin
        if (as_s) begin
          state_d = S_IDLE;
          doe_d   = 1'b0;
          cback_d = 1'b1;
        end else if (BE_ACK) begin
          // CBACK_ rides with STERM_ except on the last beat or once the CPU gave up.
          state_d = S_TERM;
          sterm_d = 1'b0;
          cback_d = burst_stop | (bidx_q == LAST_BEAT);
          burst_d = ~burst_stop;
        end else if (timeout_hit) begin
          state_d = S_ERR;
          berr_d  = 1'b0;
          doe_d   = 1'b0;
          cback_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (burst_stop) begin
            cback_d = 1'b1;
            burst_d = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (as_s) begin
          state_d = S_IDLE;
          dsack_d = DSACK_NONE;
          doe_d   = 1'b0;
          cback_d = 1'b1;
        end
      end

      S_ERR: begin
        if (as_s) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and all bus outputs registered; reset releases the bus immediately.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bidx_q   <= '0;
      beat_q   <= '0;
      sync_q   <= 1'b0;
      burst_q  <= 1'b0;
      pend_q   <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      doe_q    <= 1'b0;
      dsack_q  <= DSACK_NONE;
      sterm_q  <= 1'b1;
      cback_q  <= 1'b1;
      berr_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      beat_q   <= beat_d;
      sync_q   <= sync_d;
      burst_q  <= burst_d;
      pend_q   <= pend_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      doe_q    <= doe_d;
      dsack_q  <= dsack_d;
      sterm_q  <= sterm_d;
      cback_q  <= cback_d;
      berr_q   <= berr_d;
    end
  end

  assign RD_STB = rd_stb_q;
  assign WR_STB = wr_stb_q;
  assign BEAT   = beat_q;
  assign DOE    = doe_q;
  assign DSACK_ = dsack_q;
  assign STERM_ = sterm_q;
  assign CBACK_ = cback_q;
  assign BERR_  = berr_q;

endmodule

// File: tb/tb_cpu_term_gen.sv
// Directed bench for cpu_term_gen with default WAIT_STATES=1, TIMEOUT=63.
module tb_cpu_term_gen;

  logic       SCLK = 1'b0;
  logic       RST = 1'b1;
  logic       AS_ = 1'b1;
  logic       RW = 1'b1;
  logic       SEL = 1'b0;
  logic [1:0] A32 = 2'b00;
  logic       SYNC_EN = 1'b0;
  logic       CBREQ_ = 1'b1;
  logic       BE_ACK = 1'b0;
  logic       RD_STB, WR_STB, DOE, STERM_, CBACK_, BERR_;
  logic [1:0] BEAT, DSACK_;

  int checks = 0;
  int errors = 0;

  cpu_term_gen dut (
    .SCLK(SCLK), .RST(RST), .AS_(AS_), .RW(RW), .SEL(SEL), .A32(A32),
    .SYNC_EN(SYNC_EN), .CBREQ_(CBREQ_), .BE_ACK(BE_ACK),
    .RD_STB(RD_STB), .WR_STB(WR_STB), .BEAT(BEAT), .DOE(DOE),
    .DSACK_(DSACK_), .STERM_(STERM_), .CBACK_(CBACK_), .BERR_(BERR_)
  );

  always #5 SCLK = ~SCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic go_idle();
    AS_ = 1'b1; SEL = 1'b0; BE_ACK = 1'b0; CBREQ_ = 1'b1;
    SYNC_EN = 1'b0; RW = 1'b1; A32 = 2'b00;
    cyc(6);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc(3);
    checks++; if (DSACK_ !== 2'b11) begin errors++; $display("FAIL reset_dsack got %b exp 11", DSACK_); end
    checks++; if ({STERM_, CBACK_, BERR_} !== 3'b111) begin errors++; $display("FAIL reset_strobes got %b exp 111", {STERM_, CBACK_, BERR_}); end
    checks++; if ({RD_STB, WR_STB, DOE} !== 3'b000) begin errors++; $display("FAIL reset_rd_wr_doe got %b exp 000", {RD_STB, WR_STB, DOE}); end
    checks++; if (BEAT !== 2'b00) begin errors++; $display("FAIL reset_beat got %b exp 00", BEAT); end
    RST = 1'b0;
    cyc(3);
    checks++; if (DSACK_ !== 2'b11) begin errors++; $display("FAIL post_reset_dsack got %b exp 11", DSACK_); end
  endtask

  task automatic test_async_read();
    int t_ds, rd_n, rd_at, wr_n, t_rel;
    logic doe_at, doe_rel;
    logic [1:0] beat_at;
    t_ds = -1; rd_n = 0; rd_at = -1; wr_n = 0; t_rel = -1;
    doe_at = 1'b0; doe_rel = 1'b1; beat_at = 2'b00;
    RW = 1'b1; SYNC_EN = 1'b0; A32 = 2'b01; BE_ACK = 1'b1; SEL = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (RD_STB) begin rd_n++; rd_at = k; end
      if (WR_STB) wr_n++;
      if (t_ds < 0 && DSACK_ == 2'b00) begin t_ds = k; doe_at = DOE; beat_at = BEAT; end
    end
    checks++; if (t_ds !== 5) begin errors++; $display("FAIL ard_dsack_latency got %0d exp 5", t_ds); end
    checks++; if (rd_n !== 1 || rd_at !== 3) begin errors++; $display("FAIL ard_rd_stb got n=%0d at=%0d exp n=1 at=3", rd_n, rd_at); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL ard_wr_stb got %0d exp 0", wr_n); end
    checks++; if (doe_at !== 1'b1 || beat_at !== 2'b01) begin errors++; $display("FAIL ard_doe_beat got doe=%b beat=%b exp doe=1 beat=01", doe_at, beat_at); end
    checks++; if (DSACK_ !== 2'b00) begin errors++; $display("FAIL ard_dsack_held got %b exp 00", DSACK_); end
    AS_ = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (t_rel < 0 && DSACK_ == 2'b11) begin t_rel = k; doe_rel = DOE; end
    end
    checks++; if (t_rel !== 3) begin errors++; $display("FAIL ard_release_latency got %0d exp 3", t_rel); end
    checks++; if (doe_rel !== 1'b0) begin errors++; $display("FAIL ard_release_doe got %b exp 0", doe_rel); end
    go_idle();
  endtask

  task automatic test_sync_burst();
    logic [1:0] beats [4];
    logic       cbs [4];
    int n, rd_n, t_first;
    bit ds_seen;
    n = 0; rd_n = 0; t_first = -1; ds_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin beats[i] = 2'bxx; cbs[i] = 1'bx; end
    SYNC_EN = 1'b1; RW = 1'b1; A32 = 2'b10; BE_ACK = 1'b1; CBREQ_ = 1'b0;
    cyc(3);
    SEL = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (RD_STB) rd_n++;
      if (DSACK_ !== 2'b11) ds_seen = 1'b1;
      if (STERM_ == 1'b0) begin
        if (n < 4) begin beats[n] = BEAT; cbs[n] = CBACK_; end
        if (n == 0) t_first = k;
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL sb_sterm_count got %0d exp 4", n); end
    checks++; if (t_first !== 5) begin errors++; $display("FAIL sb_first_sterm got %0d exp 5", t_first); end
    checks++; if ({beats[0], beats[1], beats[2], beats[3]} !== 8'b10_11_00_01) begin errors++; $display("FAIL sb_beats got %b exp 10110001", {beats[0], beats[1], beats[2], beats[3]}); end
    checks++; if ({cbs[0], cbs[1], cbs[2], cbs[3]} !== 4'b0001) begin errors++; $display("FAIL sb_cback got %b exp 0001", {cbs[0], cbs[1], cbs[2], cbs[3]}); end
    checks++; if (rd_n !== 4) begin errors++; $display("FAIL sb_rd_stb got %0d exp 4", rd_n); end
    checks++; if (ds_seen !== 1'b0) begin errors++; $display("FAIL sb_dsack_used got %b exp 0", ds_seen); end
    checks++; if ({CBACK_, DOE} !== 2'b11) begin errors++; $display("FAIL sb_hold_state got cback,doe=%b exp 11", {CBACK_, DOE}); end
    AS_ = 1'b1;
    cyc(5);
    checks++; if (DOE !== 1'b0) begin errors++; $display("FAIL sb_doe_release got %b exp 0", DOE); end
    go_idle();
  endtask

  task automatic test_burst_stop();
    int t, n2;
    logic cb2;
    t = -1; n2 = 0; cb2 = 1'bx;
    SYNC_EN = 1'b1; RW = 1'b1; A32 = 2'b00; BE_ACK = 1'b1; CBREQ_ = 1'b0;
    cyc(3);
    SEL = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (STERM_ == 1'b0) begin t = k; break; end
    end
    checks++; if (t !== 5) begin errors++; $display("FAIL bs_first_sterm got %0d exp 5", t); end
    BE_ACK = 1'b0; CBREQ_ = 1'b1;
    cyc(4);
    checks++; if (CBACK_ !== 1'b1) begin errors++; $display("FAIL bs_cback_negated got %b exp 1", CBACK_); end
    BE_ACK = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      if (STERM_ == 1'b0) begin n2++; cb2 = CBACK_; end
    end
    checks++; if (n2 !== 1) begin errors++; $display("FAIL bs_extra_sterm got %0d exp 1", n2); end
    checks++; if (cb2 !== 1'b1) begin errors++; $display("FAIL bs_cback_2nd got %b exp 1", cb2); end
    checks++; if ({DOE, DSACK_} !== 3'b111) begin errors++; $display("FAIL bs_hold got doe,dsack=%b exp 111", {DOE, DSACK_}); end
    go_idle();
  endtask

  task automatic test_write_timeout();
    int t_berr, wr_n, rd_n;
    bit ds_seen, doe_seen;
    t_berr = -1; wr_n = 0; rd_n = 0; ds_seen = 1'b0; doe_seen = 1'b0;
    SYNC_EN = 1'b0; RW = 1'b0; BE_ACK = 1'b0; SEL = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      cyc(1);
      if (WR_STB) wr_n++;
      if (RD_STB) rd_n++;
      if (DSACK_ !== 2'b11 || STERM_ !== 1'b1) ds_seen = 1'b1;
      if (DOE) doe_seen = 1'b1;
      if (t_berr < 0 && BERR_ == 1'b0) t_berr = k;
    end
    checks++; if (t_berr !== 68) begin errors++; $display("FAIL wt_berr_latency got %0d exp 68", t_berr); end
    checks++; if (wr_n !== 1 || rd_n !== 0) begin errors++; $display("FAIL wt_strobes got wr=%0d rd=%0d exp wr=1 rd=0", wr_n, rd_n); end
    checks++; if (ds_seen !== 1'b0 || doe_seen !== 1'b0) begin errors++; $display("FAIL wt_no_term got term=%b doe=%b exp 0 0", ds_seen, doe_seen); end
    AS_ = 1'b1;
    cyc(4);
    checks++; if (BERR_ !== 1'b1) begin errors++; $display("FAIL wt_berr_release got %b exp 1", BERR_); end
    go_idle();
  endtask

  task automatic test_abort();
    int rd_n, t_ds;
    bit term_seen;
    rd_n = 0; t_ds = -1; term_seen = 1'b0;
    SYNC_EN = 1'b0; RW = 1'b1; BE_ACK = 1'b0; SEL = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc(1);
      if (RD_STB) rd_n++;
      if (DSACK_ !== 2'b11 || STERM_ !== 1'b1 || BERR_ !== 1'b1) term_seen = 1'b1;
      if (k == 5) AS_ = 1'b1;
    end
    checks++; if (term_seen !== 1'b0) begin errors++; $display("FAIL ab_termination got %b exp 0", term_seen); end
    checks++; if (rd_n !== 1) begin errors++; $display("FAIL ab_rd_stb got %0d exp 1", rd_n); end
    checks++; if (DOE !== 1'b0) begin errors++; $display("FAIL ab_doe got %b exp 0", DOE); end
    BE_ACK = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (t_ds < 0 && DSACK_ == 2'b00) t_ds = k;
    end
    checks++; if (t_ds !== 5) begin errors++; $display("FAIL ab_next_cycle got %0d exp 5", t_ds); end
    go_idle();
  endtask

  task automatic test_sel_low();
    bit act;
    act = 1'b0;
    SEL = 1'b0; RW = 1'b1; BE_ACK = 1'b1; AS_ = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (RD_STB || WR_STB || DOE || DSACK_ !== 2'b11 || STERM_ !== 1'b1) act = 1'b1;
    end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL sl_activity got %b exp 0", act); end
    go_idle();
  endtask

  task automatic test_reset_hold();
    SYNC_EN = 1'b0; RW = 1'b1; BE_ACK = 1'b1; SEL = 1'b1; AS_ = 1'b0;
    cyc(7);
    checks++; if ({DSACK_, DOE} !== 3'b001) begin errors++; $display("FAIL rh_before got dsack,doe=%b exp 001", {DSACK_, DOE}); end
    #2 RST = 1'b1;
    #1;
    checks++; if ({DSACK_, DOE} !== 3'b110) begin errors++; $display("FAIL rh_async got dsack,doe=%b exp 110", {DSACK_, DOE}); end
    cyc(2);
    RST = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_async_read();
    test_sync_burst();
    test_burst_stop();
    test_write_timeout();
    test_abort();
    test_sel_low();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
